vga_sync: RTL and testbench
===========================

# vga_sync

Display timing stage that sits directly downstream of the horizontal pixel `Counter`. It consumes that counter's 12-bit position and end-of-line carry. It keeps its own line counter, decodes porch, sync and active regions on both axes, and drives registered hsync, vsync, display-enable and pixel coordinates to the renderer and the VGA pins. It also provides a per-frame start pulse and a sticky protocol-error flag.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick; the same enable that drives the upstream counter
- h_cnt  in  12  horizontal position from the counter, 0..H_TOTAL-1
- h_carry  in  1  end-of-line pulse from the counter; high in the pix_en cycle with h_cnt = H_TOTAL-1
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- de  out  1  display enable; high in the active region
- px_x  out  12  pixel column; valid while de=1
- px_y  out  12  pixel row; valid while de=1
- frame_start  out  1  one-clock pulse marking the first active pixel of a frame
- line_err  out  1  sticky flag for a carry/count protocol violation

## Operation
- Region order on each axis, starting at count 0: ACTIVE, FP, SYNC, BP.
- Internal line counter v_cnt is 12 bits.
  - It advances only on cycles with pix_en=1 and h_carry=1.
  - At V_TOTAL-1 it wraps to 0; otherwise it increments by 1.
- Vertical state machine has states V_ACT, V_FP, V_SYNC and V_BP.
  - Transitions happen only on a line advance.
  - V_ACT goes to V_FP when v_cnt reaches V_ACTIVE.
  - V_FP goes to V_SYNC at V_ACTIVE+V_FP.
  - V_SYNC goes to V_BP at V_ACTIVE+V_FP+V_SYNC.
  - V_BP goes to V_ACT on the wrap to 0.
- Horizontal region is decoded from h_cnt in the same cycle it is sampled.
  - hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is asserted for whole lines while the vertical state is V_SYNC. Edges are aligned to h_cnt = 0.
- de = (h_cnt < H_ACTIVE) and (vertical state = V_ACT).
- When de=1: px_x = h_cnt and px_y = v_cnt.
- When de=0: px_x and px_y hold their last values.
- frame_start is set for one clock when a pix_en cycle samples h_cnt=0 and v_cnt=0.
- line_err is set, and stays set until reset, in two cases:
  - h_carry=1 while h_cnt != H_TOTAL-1. The carry still advances v_cnt; the carry is authoritative.
  - h_cnt >= H_TOTAL is sampled. That cycle is treated as blanking: de=0 and hsync is inactive.
- Reset values:
  - hsync = vsync = ~SYNC_POL (inactive)
  - de = 0, px_x = 0, px_y = 0
  - frame_start = 0, line_err = 0
  - v_cnt = 0, vertical state = V_ACT

## Timing
- All outputs are registered, with 1-clock latency: values sampled on the edge where pix_en=1 appear immediately after that edge.
- pix_en=0:
  - hsync, vsync, de, px_x, px_y and v_cnt hold.
  - frame_start returns to 0, so it is never longer than one clock.
  - h_carry is ignored.
- Line boundary: the cycle sampling h_cnt=H_TOTAL-1 uses the old v_cnt. The next sampled h_cnt=0 uses the new v_cnt, because v_cnt updates on the same edge.
- Wrap-around: after line V_TOTAL-1, the next line is 0 and frame_start fires on its first pixel.
- Reset may be asserted at any time, including mid-frame or mid-sync.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first pix_en cycle with h_cnt=0 produces frame_start.
- Throughput: one pixel per pix_en cycle; there are no stall cycles.

## Test plan
- Reset check: hold reset for 5 clocks with random inputs. Expect hsync=1, vsync=1, de=0, px_x=px_y=0, frame_start=0 and line_err=0 throughout.
- Single line, default parameters, pix_en=1 continuously:
  - de=1 for samples h=0..639, with px_x tracking 0..639.
  - hsync=0 exactly for samples h=656..751 (96 clocks).
- Full frame:
  - vsync=0 for all of lines 490 and 491 (1600 enabled cycles).
  - de is never 1 on lines 480..524.
  - frame_start pulses exactly once per 420000 enabled cycles, together with px_x=0 and px_y=0.
- pix_en gaps: alternate pix_en 1/0 across a line. Expect outputs to hold during 0-cycles, frame_start width = 1 clock, and line timing unchanged in enabled-cycle units.
- Protocol error: inject h_carry at h_cnt=100. Expect line_err=1 from the next clock and staying high, with v_cnt advancing. Then sample h_cnt=900: expect de=0 and hsync inactive.
- Reset mid-frame: assert reset at line 300, h=200, then release. Expect all outputs at reset values, and the first h=0 sample to give frame_start=1 with px_y=0.

Source files
------------

// File: rtl/vga_sync.sv
// vga_sync: VGA timing stage that turns the upstream pixel count and line carry into
// registered hsync/vsync/de, pixel coordinates, a frame-start pulse and a sticky error flag.
module vga_sync #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [11:0] h_cnt,
  input  logic        h_carry,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] px_x,
  output logic [11:0] px_y,
  output logic        frame_start,
  output logic        line_err
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] L_HA  = 12'(H_ACTIVE);
  localparam logic [11:0] L_HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] L_HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] L_HT  = 12'(H_TOTAL);
  localparam logic [11:0] L_VA  = 12'(V_ACTIVE);
  localparam logic [11:0] L_VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] L_VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] L_VT  = 12'(V_TOTAL);
  typedef enum logic [1:0] {S_ACT, S_FP, S_SYNC, S_BP} st_t;
  st_t         r_st, w_st_nxt;
  logic [11:0] r_v_cnt, w_v_nxt;
  logic        w_adv, w_hs_on, w_de, w_fs, w_err;
  logic        r_hs, r_vs, r_de, r_fs, r_err;
  logic [11:0] r_x, r_y;
  assign w_adv   = pix_en && h_carry;
  assign w_v_nxt = (r_v_cnt == L_VT - 12'd1) ? 12'd0 : r_v_cnt + 12'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_st    <= S_ACT;
      r_v_cnt <= 12'd0;
    end else if (w_adv) begin
      r_st    <= w_st_nxt;
      r_v_cnt <= w_v_nxt;
    end
  // The carry is authoritative: it advances the line even when h_cnt disagrees.
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_ACT:  w_st_nxt = (w_v_nxt == L_VA)  ? S_FP   : S_ACT;
      S_FP:   w_st_nxt = (w_v_nxt == L_VS0) ? S_SYNC : S_FP;
      S_SYNC: w_st_nxt = (w_v_nxt == L_VS1) ? S_BP   : S_SYNC;
      S_BP:   w_st_nxt = (w_v_nxt == 12'd0) ? S_ACT  : S_BP;
      default: w_st_nxt = S_ACT;
    endcase
  end
  always_comb begin
    w_hs_on = (h_cnt >= L_HS0) && (h_cnt < L_HS1);
    w_de    = (h_cnt < L_HA) && (r_st == S_ACT);
    w_fs    = pix_en && (h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    w_err   = (h_carry && (h_cnt != L_HT - 12'd1)) || (h_cnt >= L_HT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
      r_de  <= 1'b0;
      r_x   <= 12'd0;
      r_y   <= 12'd0;
      r_fs  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_fs <= w_fs;
      if (pix_en) begin
        r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
        r_vs  <= (r_st == S_SYNC) ? SYNC_POL : ~SYNC_POL;
        r_de  <= w_de;
        r_err <= r_err | w_err;
        if (w_de) begin
          r_x <= h_cnt;
          r_y <= r_v_cnt;
        end
      end
    end
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign px_x        = r_x;
  assign px_y        = r_y;
  assign frame_start = r_fs;
  assign line_err    = r_err;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: randomized bench for vga_sync with a line-number based reference model,
// run on a reduced raster so that several whole frames fit in a short run.
module tb_vga_sync;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0, h_carry = 1'b0;
  logic [11:0] h_cnt = 12'd0;
  logic        hsync, vsync, de, frame_start, line_err;
  logic [11:0] px_x, px_y;
  int n_chk = 0, n_fail = 0;
  int m_v, e_x, e_y, u_h = 0;
  logic e_hs, e_vs, e_de, e_fs, e_err;
  always #5 clk = ~clk;
  vga_sync #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut (
    .clk(clk), .reset(rst), .pix_en(pix_en), .h_cnt(h_cnt), .h_carry(h_carry),
    .hsync(hsync), .vsync(vsync), .de(de), .px_x(px_x), .px_y(px_y),
    .frame_start(frame_start), .line_err(line_err));
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: region membership is computed directly from the line number and pixel index.
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_v <= 0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0;
      e_x <= 0; e_y <= 0; e_fs <= 1'b0; e_err <= 1'b0;
    end else begin
      e_fs <= pix_en && h_cnt == 0 && m_v == 0;
      if (pix_en) begin
        e_hs <= !(h_cnt >= HA + HF && h_cnt < HA + HF + HS);
        e_vs <= !(m_v >= VA + VF && m_v < VA + VF + VS);
        e_de <= h_cnt < HA && m_v < VA;
        if (h_cnt < HA && m_v < VA) begin
          e_x <= int'(h_cnt);
          e_y <= m_v;
        end
        if (h_carry) m_v <= (m_v + 1) % VT;
        if ((h_carry && h_cnt != HT - 1) || h_cnt >= HT) e_err <= 1'b1;
      end
    end
  always @(negedge clk) begin
    chk("hsync", int'(hsync), int'(e_hs));
    chk("vsync", int'(vsync), int'(e_vs));
    chk("de", int'(de), int'(e_de));
    chk("px_x", int'(px_x), e_x);
    chk("px_y", int'(px_y), e_y);
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("line_err", int'(line_err), int'(e_err));
  end
  task automatic step(input logic pe, input int h, input logic c);
    pix_en = pe; h_cnt = 12'(h); h_carry = c;
    @(posedge clk); #1;
  endtask
  task automatic tick(input logic pe);
    step(pe, u_h, pe && u_h == HT - 1);
    if (pe) u_h = (u_h + 1) % HT;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_px_x"}, int'(px_x), 0);
    chk({tag, "_px_y"}, int'(px_y), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_err"}, int'(line_err), 0);
  endtask
  initial begin
    int c_de, c_hs, c_vs, c_fs, c_wide, en;
    logic pe, prev_fs;
    repeat (5) step(1'($urandom_range(0, 1)), $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
    chk_reset_vals("reset");
    rst = 1'b0;
    u_h = 0;
    c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick(1'b1);
      if (i == 0) begin
        chk("first_fs", int'(frame_start), 1);
        chk("first_de", int'(de), 1);
      end
      c_de += int'(de);
      c_hs += int'(!hsync);
      c_vs += int'(!vsync);
      c_fs += int'(frame_start);
      if (frame_start) begin
        chk("fs_px_x", int'(px_x), 0);
        chk("fs_px_y", int'(px_y), 0);
      end
    end
    chk("de_count", c_de, 320);
    chk("hsync_low_count", c_hs, 136);
    chk("vsync_low_count", c_vs, 100);
    chk("fs_count", c_fs, 2);
    en = 0; c_fs = 0; c_wide = 0; prev_fs = 1'b0;
    for (int i = 0; en < 2 * HT * VT && i < 20000; i++) begin
      pe = (i < 2 * HT) ? 1'(i % 2 == 0) : 1'($urandom_range(0, 2) != 0);
      tick(pe);
      en += int'(pe);
      c_fs += int'(frame_start);
      c_wide += int'(frame_start && prev_fs);
      prev_fs = frame_start;
    end
    chk("gap_enabled_cycles", en, 2 * HT * VT);
    chk("gap_fs_count", c_fs, 2);
    chk("gap_fs_wide", c_wide, 0);
    chk("err_clean", int'(line_err), 0);
    repeat (3) tick(1'b1);
    step(1'b1, u_h, 1'b1);
    u_h = (u_h + 1) % HT;
    chk("err_set", int'(line_err), 1);
    repeat (HT) tick(1'b1);
    chk("err_sticky", int'(line_err), 1);
    step(1'b1, 30, 1'b0);
    chk("oob_de", int'(de), 0);
    chk("oob_hsync", int'(hsync), 1);
    repeat (300) step(1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < 2000 && !(u_h == 10 && m_v == 7); i++) tick(1'b1);
    chk("reach_line", int'(u_h == 10 && m_v == 7), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    repeat (3) step(1'($urandom_range(0, 1)), $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
    rst = 1'b0;
    u_h = 0;
    tick(1'b1);
    chk("restart_fs", int'(frame_start), 1);
    chk("restart_px_y", int'(px_y), 0);
    chk("restart_de", int'(de), 1);
    repeat (HT * VT) tick(1'($urandom_range(0, 3) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
